// File: rtl/subtractor_64bit_serial.sv
// subtractor_64bit_serial
// Multi-cycle 64-bit subtractor: Diff = A - B - Bin, one SLICE_W-bit slice
// per clock through a single narrow adder slice (A_k + ~B_k + ~borrow).
// A start/busy/done handshake sequences the operation; every output is a
// register, so there is no combinational path from inputs to outputs.
// SLICE_W must divide 64 (1, 2, 4, 8, 16, 32 or 64).

module subtractor_64bit_serial #(
   parameter int SLICE_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] A,
   input  logic [63:0] B,
   input  logic        Bin,
   output logic [63:0] Diff,
   output logic        Bout,
   output logic        Overflow,
   output logic        Zero,
   output logic        busy,
   output logic        done
);

   // Number of compute cycles and the width of the slice counter.  With a
   // single slice the counter still needs one bit to stay a legal vector.
   localparam int NSLICE = 64 / SLICE_W;
   localparam int K_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t            r_state;
   logic [63:0]       r_a;          // latched minuend
   logic [63:0]       r_b;          // latched subtrahend
   logic [63:0]       r_res;        // partial result, filled slice by slice
   logic              r_borrow;     // borrow into the current slice
   logic [K_W-1:0]    r_k;          // index of the slice being processed
   logic [63:0]       r_diff;
   logic              r_bout;
   logic              r_overflow;
   logic              r_zero;
   logic              r_busy;
   logic              r_done;

   // ------------------------------------------------------------------
   // Combinational nets
   // ------------------------------------------------------------------
   state_t            w_state_next;
   logic              w_accept;     // operation accepted on this edge
   logic              w_run;        // a slice is processed on this edge
   logic              w_last;       // the slice being processed is the last
   logic [SLICE_W-1:0] w_a_k;
   logic [SLICE_W-1:0] w_b_k;
   logic [SLICE_W-1:0] w_d;
   logic              w_c;
   logic [63:0]       w_res_full;   // partial result with slice k merged in
   logic              w_busy_next;
   logic              w_done_next;

   // A new operation is taken in IDLE, or in DONE for back-to-back issue.
   // While RUN is active a start request is simply ignored.
   assign w_accept = start && (r_state != S_RUN);
   assign w_run    = (r_state == S_RUN);
   assign w_last   = (r_k == K_LAST);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last
   // slice, DONE lasts one cycle and may re-enter RUN directly.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               w_state_next = S_RUN;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Output decode: busy and done are registered, so they are decoded from
   // the state we are about to enter rather than the current one.
   always_comb begin
      w_busy_next = (w_state_next == S_RUN);
      w_done_next = w_run && w_last;
   end

   // Registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= w_busy_next;
         r_done <= w_done_next;
      end
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------

   // Select operand slice k.  Written as a compare-per-slice mux so that
   // the select stays a plain one-hot AND-OR for any SLICE_W.
   always_comb begin
      w_a_k = '0;
      w_b_k = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (r_k == K_W'(i)) begin
            w_a_k = r_a[i*SLICE_W +: SLICE_W];
            w_b_k = r_b[i*SLICE_W +: SLICE_W];
         end
      end
   end

   // The single shared adder slice.  Subtraction is addition of the
   // complement; the carry-in is the complement of the running borrow, and
   // the carry-out is the complement of the borrow into the next slice.
   assign {w_c, w_d} = {1'b0, w_a_k}
                     + {1'b0, ~w_b_k}
                     + {{SLICE_W{1'b0}}, ~r_borrow};

   // Merge the freshly computed slice into the partial result.  The final
   // Diff is taken from this merged value so the last slice is included on
   // the completion edge itself.
   generate
      for (genvar gi = 0; gi < NSLICE; gi++) begin : g_merge
         assign w_res_full[gi*SLICE_W +: SLICE_W] =
            (r_k == K_W'(gi)) ? w_d : r_res[gi*SLICE_W +: SLICE_W];
      end
   endgenerate

   // Operand latch, slice counter, running borrow and partial result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_borrow <= 1'b0;
         r_k      <= '0;
      end else if (w_accept) begin
         r_a      <= A;
         r_b      <= B;
         r_borrow <= Bin;
         r_k      <= '0;
      end else if (w_run) begin
         r_res    <= w_res_full;
         r_borrow <= ~w_c;
         r_k      <= r_k + K_W'(1);
      end
   end

   // Result registers: updated only on the completion edge and held until
   // the next completion, so an aborted or in-flight operation never
   // disturbs the last published result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_diff     <= '0;
         r_bout     <= 1'b0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
      end else if (w_run && w_last) begin
         r_diff     <= w_res_full;
         r_bout     <= ~w_c;
         // Signed overflow: operands of opposite sign and a result whose
         // sign differs from the minuend.
         r_overflow <= (r_a[63] ^ r_b[63]) & (w_res_full[63] ^ r_a[63]);
         r_zero     <= (w_res_full == 64'd0);
      end
   end

   assign Diff     = r_diff;
   assign Bout     = r_bout;
   assign Overflow = r_overflow;
   assign Zero     = r_zero;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_subtractor_64bit_serial.sv
// Testbench for subtractor_64bit_serial.
// Three instances (SLICE_W = 8, 1, 64) are exercised one after another
// with directed vectors, handshake corner cases and random operands; all
// results are compared against a plain-arithmetic reference model.

module tb_subtractor_64bit_serial;

   localparam int NU = 3;

   function automatic int sw_of(input int u);
      return (u == 0) ? 8 : ((u == 1) ? 1 : 64);
   endfunction

   localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
   localparam logic signed [65:0] SMIN = -66'sd9223372036854775808;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_v   [NU];
   logic        start_v [NU];
   logic [63:0] a_v     [NU];
   logic [63:0] b_v     [NU];
   logic        bin_v   [NU];
   logic [63:0] diff_v  [NU];
   logic        bout_v  [NU];
   logic        ovf_v   [NU];
   logic        zero_v  [NU];
   logic        busy_v  [NU];
   logic        done_v  [NU];

   generate
      for (genvar gi = 0; gi < NU; gi++) begin : g_dut
         subtractor_64bit_serial #(.SLICE_W(sw_of(gi))) u_dut (
            .clk      (clk),
            .rst      (rst_v[gi]),
            .start    (start_v[gi]),
            .A        (a_v[gi]),
            .B        (b_v[gi]),
            .Bin      (bin_v[gi]),
            .Diff     (diff_v[gi]),
            .Bout     (bout_v[gi]),
            .Overflow (ovf_v[gi]),
            .Zero     (zero_v[gi]),
            .busy     (busy_v[gi]),
            .done     (done_v[gi])
         );
      end
   endgenerate

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%h expected=0x%h", tag, got, exp);
      end
   endtask

   // Reference model: unsigned and signed arithmetic on wide integers.
   function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic bin,
                                 output logic [63:0] d, output logic bo,
                                 output logic ov, output logic z);
      logic signed [65:0] s;
      d  = a - b - 64'(bin);
      bo = ({1'b0, a} < ({1'b0, b} + 65'(bin)));
      s  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, bin});
      ov = (s > SMAX) || (s < SMIN);
      z  = (d == 64'd0);
   endfunction

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        bin;
      logic [63:0] d;
      logic        bo;
      logic        ov;
      logic        z;
   } vec_t;

   vec_t dirs [8];

   task automatic init_dirs();
      dirs[0] = '{64'd100, 64'd1, 1'b0, 64'd99, 1'b0, 1'b0, 1'b0};
      dirs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
      dirs[2] = '{64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
      dirs[3] = '{64'd5, 64'd5, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
      dirs[4] = '{64'd5, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
      dirs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
      dirs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
      dirs[7] = '{64'd10, 64'd3, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0};
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an operation with start=1 and let the next edge accept it.
   task automatic accept(input int u, input logic [63:0] a, input logic [63:0] b, input logic bin);
      a_v[u]     = a;
      b_v[u]     = b;
      bin_v[u]   = bin;
      start_v[u] = 1'b1;
      tick();
   endtask

   // Called just after the accept edge; waits (bounded) for done.  When
   // poke >= 0 a competing start with new operands is raised on that cycle.
   task automatic wait_done(input int u, input int poke, input logic [63:0] pa, input logic [63:0] pb,
                            output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (!done_v[u] && lat < 200) begin
         if (busy_v[u]) bcnt++;
         if (poke >= 0) begin
            if (lat == poke) begin
               start_v[u] = 1'b1;
               a_v[u]     = pa;
               b_v[u]     = pb;
               bin_v[u]   = ~bin_v[u];
            end else if (lat == poke + 1) begin
               start_v[u] = 1'b0;
            end
         end
         tick();
         lat++;
      end
   endtask

   task automatic check_result(input int u, input string tag, input logic [63:0] a, input logic [63:0] b,
                               input logic bin, input int lat, input int bcnt);
      logic [63:0] d;
      logic        bo, ov, z;
      int          nl;
      nl = 64 / sw_of(u);
      model(a, b, bin, d, bo, ov, z);
      $display("op u%0d %s A=%h B=%h Bin=%b -> Diff=%h Bout=%b Ovf=%b Zero=%b lat=%0d",
               u, tag, a, b, bin, diff_v[u], bout_v[u], ovf_v[u], zero_v[u], lat);
      chk($sformatf("u%0d %s latency", u, tag), 64'(lat), 64'(nl));
      chk($sformatf("u%0d %s busy_cycles", u, tag), 64'(bcnt), 64'(nl));
      chk($sformatf("u%0d %s done", u, tag), 64'(done_v[u]), 64'd1);
      chk($sformatf("u%0d %s busy_at_done", u, tag), 64'(busy_v[u]), 64'd0);
      chk($sformatf("u%0d %s Diff", u, tag), diff_v[u], d);
      chk($sformatf("u%0d %s Bout", u, tag), 64'(bout_v[u]), 64'(bo));
      chk($sformatf("u%0d %s Overflow", u, tag), 64'(ovf_v[u]), 64'(ov));
      chk($sformatf("u%0d %s Zero", u, tag), 64'(zero_v[u]), 64'(z));
   endtask

   task automatic run_check(input int u, input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic bin);
      int lat, bcnt;
      accept(u, a, b, bin);
      start_v[u] = 1'b0;
      wait_done(u, -1, 64'd0, 64'd0, lat, bcnt);
      check_result(u, tag, a, b, bin, lat, bcnt);
      tick();
      chk($sformatf("u%0d %s done_one_cycle", u, tag), 64'(done_v[u]), 64'd0);
   endtask

   task automatic chk_all_zero(input int u, input string tag);
      chk($sformatf("u%0d %s Diff", u, tag), diff_v[u], 64'd0);
      chk($sformatf("u%0d %s Bout", u, tag), 64'(bout_v[u]), 64'd0);
      chk($sformatf("u%0d %s Overflow", u, tag), 64'(ovf_v[u]), 64'd0);
      chk($sformatf("u%0d %s Zero", u, tag), 64'(zero_v[u]), 64'd0);
      chk($sformatf("u%0d %s busy", u, tag), 64'(busy_v[u]), 64'd0);
      chk($sformatf("u%0d %s done", u, tag), 64'(done_v[u]), 64'd0);
   endtask

   task automatic test_unit(input int u);
      int          nl, lat, bcnt, t_done1, t_done2, n_rand, pre;
      logic [63:0] ra, rb;
      logic        rbin;
      nl = 64 / sw_of(u);

      // Reset held for two edges with start high: nothing may start.
      rst_v[u]   = 1'b1;
      start_v[u] = 1'b1;
      a_v[u]     = 64'd100;
      b_v[u]     = 64'd1;
      repeat (2) begin
         tick();
         chk_all_zero(u, "reset");
      end
      rst_v[u]   = 1'b0;
      start_v[u] = 1'b0;
      tick();
      chk($sformatf("u%0d post_reset busy", u), 64'(busy_v[u]), 64'd0);

      // Directed vectors with explicit expected values.
      for (int i = 0; i < 8; i++) begin
         run_check(u, $sformatf("dir%0d", i), dirs[i].a, dirs[i].b, dirs[i].bin);
         chk($sformatf("u%0d dir%0d Diff_const", u, i), diff_v[u], dirs[i].d);
         chk($sformatf("u%0d dir%0d Bout_const", u, i), 64'(bout_v[u]), 64'(dirs[i].bo));
         chk($sformatf("u%0d dir%0d Ovf_const", u, i), 64'(ovf_v[u]), 64'(dirs[i].ov));
         chk($sformatf("u%0d dir%0d Zero_const", u, i), 64'(zero_v[u]), 64'(dirs[i].z));
      end

      // start and operand changes while busy are ignored; no extra done.
      accept(u, 64'h0F0F_0F0F_1234_5678, 64'h0101_0101_0000_0042, 1'b1);
      start_v[u] = 1'b0;
      wait_done(u, (nl >= 3) ? 2 : -1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, lat, bcnt);
      check_result(u, "midstart", 64'h0F0F_0F0F_1234_5678, 64'h0101_0101_0000_0042, 1'b1, lat, bcnt);
      start_v[u] = 1'b0;
      repeat (nl + 3) begin
         tick();
         chk($sformatf("u%0d midstart no_extra_done", u), 64'(done_v[u]), 64'd0);
      end

      // Back-to-back: start held high across DONE; operands changed mid-run.
      accept(u, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
      a_v[u]   = 64'd3;
      b_v[u]   = 64'h10;
      bin_v[u] = 1'b1;
      wait_done(u, -1, 64'd0, 64'd0, lat, bcnt);
      t_done1 = cyc;
      check_result(u, "b2b_first", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, lat, bcnt);
      tick();
      start_v[u] = 1'b0;
      chk($sformatf("u%0d b2b accept busy", u), 64'(busy_v[u]), 64'(nl > 1 ? 1 : 1));
      chk($sformatf("u%0d b2b accept done", u), 64'(done_v[u]), 64'd0);
      wait_done(u, -1, 64'd0, 64'd0, lat, bcnt);
      t_done2 = cyc;
      check_result(u, "b2b_second", 64'd3, 64'h10, 1'b1, lat, bcnt);
      chk($sformatf("u%0d b2b done_spacing", u), 64'(t_done2 - t_done1), 64'(nl + 1));
      tick();
      chk($sformatf("u%0d b2b done_one_cycle", u), 64'(done_v[u]), 64'd0);

      // Reset during RUN: the aborted operation never completes.
      run_check(u, "pre_abort", 64'd100, 64'd1, 1'b0);
      accept(u, 64'hDEAD_BEEF_0000_0001, 64'h42, 1'b1);
      start_v[u] = 1'b0;
      pre = (nl < 4) ? nl : 4;
      repeat (pre - 1) tick();
      chk($sformatf("u%0d abort held_Diff", u), diff_v[u], 64'd99);
      rst_v[u] = 1'b1;
      tick();
      rst_v[u] = 1'b0;
      chk_all_zero(u, "abort");
      repeat (nl + 3) begin
         tick();
         chk($sformatf("u%0d abort no_done", u), 64'(done_v[u]), 64'd0);
         chk($sformatf("u%0d abort Diff_held", u), diff_v[u], 64'd0);
      end
      run_check(u, "after_abort", 64'd10, 64'd3, 1'b0);
      chk($sformatf("u%0d after_abort Diff_const", u), diff_v[u], 64'd7);

      // Random operands, occasionally forced equal or sign-boundary.
      n_rand = (u == 1) ? 20 : 40;
      for (int i = 0; i < n_rand; i++) begin
         ra   = {$urandom(), $urandom()};
         rb   = {$urandom(), $urandom()};
         rbin = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: rb = ra;
            1: ra = {1'b1, 63'd0} ^ {32'd0, ra[31:0]};
            2: rb = ra + 64'(rbin);
            default: ;
         endcase
         run_check(u, $sformatf("rand%0d", i), ra, rb, rbin);
      end
   endtask

   initial begin
      for (int u = 0; u < NU; u++) begin
         rst_v[u]   = 1'b1;
         start_v[u] = 1'b0;
         a_v[u]     = 64'd0;
         b_v[u]     = 64'd0;
         bin_v[u]   = 1'b0;
      end
      init_dirs();
      tick();
      for (int u = 0; u < NU; u++) begin
         test_unit(u);
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1, "timeout");
   end

endmodule
